imem_fetch_responder: RTL and testbench
=======================================

// Module: imem_fetch_responder
// PURPOSE
//  Instruction-memory responder: the far end of the program counter's fetch
//  address. Accepts a 32-bit byte-address fetch request and returns the
//  instruction word after a fixed LATENCY. Reports misaligned or out-of-range
//  addresses as an error.
//  A loader write port fills the array before and during execution.
// PARAMETERS
//  DEPTH      256            number of 32-bit words; power of 2, >=2
//  LATENCY    2              cycles from request accept to rvalid; >=1, <=15
//  BASE_ADDR  32'h0000_0000  byte address of word 0; DEPTH*4-aligned
// PORTS
//  clk       in   1   clock; all logic on rising edge
//  rst_n     in   1   synchronous reset, active low
//  req       in   1   fetch request; accepted on an edge where req & ready
//  addr      in   32  fetch byte address (PC value), sampled on accept
//  ready     out  1   responder can accept a request this cycle
//  rvalid    out  1   one-cycle pulse: rdata/err valid
//  rdata     out  32  instruction word; 0 when err
//  err       out  1   qualifies rvalid: misaligned or out-of-range address
//  ld_we     in   1   loader write enable
//  ld_addr   in   32  loader byte address; low 2 bits ignored
//  ld_wdata  in   32  loader write data
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state IDLE, ready=1 after reset,
//    rvalid=0, rdata=0, err=0, wait counter=0, captured addr=0. Array contents
//    NOT cleared. Reset mid-operation drops the in-flight fetch silently; no rvalid.
//  - FSM states IDLE, WAIT, RESP. ready=1 in IDLE and RESP, 0 in WAIT.
//  - Accept in IDLE or RESP: capture addr; if LATENCY==1 go RESP next cycle,
//    else go WAIT with counter=LATENCY-1.
//  - WAIT: decrement the counter each cycle. When counter==1, go to RESP next.
//  - RESP: rvalid=1 for exactly this cycle. With no req, go to IDLE next.
//    With req, accept and branch as above. Back-to-back throughput is one
//    fetch per LATENCY cycles.
//  - Latency: accept at edge N -> rvalid high in the cycle after edge N+LATENCY-1
//    (i.e. rvalid seen at edge N+LATENCY).
//  - Array read occurs on the edge entering RESP; rdata is registered and held
//    until the next RESP. Outside RESP, rdata holds its last value.
//  - Address check on the captured addr: addr[1:0]!=0 -> err. (addr-BASE_ADDR)
//    >= DEPTH*4, or addr < BASE_ADDR -> err. On err: rdata=0, no array read.
//  - Word index = (addr-BASE_ADDR)[log2(DEPTH)+1:2].
//  - Loader: ld_we writes ld_wdata at its word index, in any state, on the edge.
//    Out-of-range ld_addr is dropped. Write is unaffected by req/ready.
//  - Simultaneous loader write and fetch read of the same word on the edge
//    entering RESP: read returns OLD data (read-before-write).
//  - req while ready=0 is ignored, not queued. The initiator must hold req.
//  - addr=32'hFFFF_FFFC with BASE 0: subtraction is 32-bit unsigned, no wrap
//    into range; flagged out-of-range.
// STRUCTURE
//  - Shared package imem_pkg: FSM state encoding (IDLE=2'd0, WAIT=2'd1,
//    RESP=2'd2), WORD_BYTES=4, and the ADDR_W=32 constant.
//  - One sub-module imem_array: 1R1W synchronous RAM (DEPTH x 32) with a
//    registered read and read-before-write semantics.
//  - Top level: FSM, wait counter, address check, and output registers.
// TESTING
//  1 Reset: hold rst_n=0 for 2 edges with req=1 -> ready=1, rvalid=0,
//    rdata=0, err=0. Load word 3=32'h2008_0005, then
//    fetch addr=32'hC -> rvalid at accept+2 with rdata=32'h2008_0005, err=0.
//  2 Back-to-back (LATENCY=2): req held for addr 0,4,8 -> rvalid pulses every
//    2 cycles with words 0,1,2 in order. ready=0 only in WAIT cycles.
//  3 Errors: addr=32'h6 -> err=1, rdata=0. addr=DEPTH*4 -> err=1, rdata=0.
//    Both take the same latency as a good fetch.
//  4 Collision: word 5=A; fetch addr 0x14 with ld_we on word 5 = B on the edge
//    entering RESP -> rdata=A. A refetch returns B.
//  5 Reset mid-op: accept fetch, assert rst_n=0 during WAIT -> no rvalid, state
//    IDLE, ready=1 after release. Array contents are preserved (refetch ok).
//  6 LATENCY=1 build: fetch at every edge -> rvalid on every cycle after the first.
//    ready is stuck at 1.

Source files
------------

// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory fetch responder: FSM state
// encoding, bus widths and the bytes-per-word constant.
// ---------------------------------------------------------------------------
package imem_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned DATA_W     = WORD_BYTES * 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/imem_array.sv
// ---------------------------------------------------------------------------
// imem_array
// 1R1W synchronous instruction RAM, DEPTH x DATA_W. The read is registered;
// a read and a write of the same word on one edge returns the old word.
// The storage is never cleared; only the read register resets.
// Ports:
//   clk    in   clock
//   rst_n  in   synchronous active-low reset (read register only)
//   re     in   read enable; rdata loads mem[raddr] on the edge
//   raddr  in   read word index
//   rdata  out  registered read data, held between reads
//   we     in   write enable
//   waddr  in   write word index
//   wdata  in   write data
// ---------------------------------------------------------------------------
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Nonblocking update of mem_q gives read-before-write on a collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/imem_fetch_responder.sv
// ---------------------------------------------------------------------------
// imem_fetch_responder
// Instruction-memory responder at the far end of the PC fetch path. Accepts a
// byte-address fetch and returns the word LATENCY cycles later, flagging
// misaligned or out-of-range addresses. A loader port writes the array in any
// state.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no fetch in flight, ready=1
//   ST_WAIT  | fetch accepted, down-counting to terminal count 1, ready=0
//   ST_RESP  | rvalid pulse cycle; may accept the next fetch, ready=1
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req, addr, ready      fetch request handshake (accept on req & ready)
//   rvalid, rdata, err    one-cycle response; rdata=0 when err
//   ld_we, ld_addr, ld_wdata  loader write port (byte address, low bits ignored)
// ---------------------------------------------------------------------------
module imem_fetch_responder
    import imem_pkg::*;
#(
    parameter int unsigned       DEPTH     = 256,
    parameter int unsigned       LATENCY   = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    output logic              ready,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata
);

    localparam int unsigned       IDX_W = $clog2(DEPTH);
    localparam int unsigned       CNT_W = 4;
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH * WORD_BYTES);

    // Unsigned compare first so addresses below BASE never wrap into range.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ready_q, ready_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;
    logic              fetch_bad;
    logic              going_resp;
    logic              arr_re;
    logic [DATA_W-1:0] arr_rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;

        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (req) begin
                    addr_d = addr;
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // addr_d is the address of whichever fetch enters RESP on this edge:
        // the captured one from WAIT, or the incoming one when LATENCY==1.
        going_resp = (state_d == ST_RESP);
        fetch_bad  = (addr_d[1:0] != 2'b00) || !in_range(addr_d);
        arr_re     = going_resp && !fetch_bad;

        ready_d  = (state_d != ST_WAIT);
        rvalid_d = going_resp;
        err_d    = going_resp ? fetch_bad : err_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    imem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .re    (arr_re),
        .raddr (word_idx(addr_d)),
        .rdata (arr_rdata),
        .we    (ld_we && in_range(ld_addr)),
        .waddr (word_idx(ld_addr)),
        .wdata (ld_wdata)
    );

    // The read register is not loaded on an error, so mask it while err holds.
    assign ready  = ready_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;
    assign rdata  = err_q ? '0 : arr_rdata;

endmodule

// File: tb/tb_imem_fetch_responder.sv
module tb_imem_fetch_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n;
    logic        req, ready, rvalid, err, ld_we;
    logic [31:0] addr, rdata, ld_addr, ld_wdata;

    logic        req1, ready1, rvalid1, err1, ld_we1;
    logic [31:0] addr1, rdata1, ld_addr1, ld_wdata1;

    imem_fetch_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .BASE_ADDR(32'h0)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .ready(ready),
        .rvalid(rvalid), .rdata(rdata), .err(err),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata)
    );

    imem_fetch_responder #(.DEPTH(DEPTH), .LATENCY(1), .BASE_ADDR(32'h0)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .addr(addr1), .ready(ready1),
        .rvalid(rvalid1), .rdata(rdata1), .err(err1),
        .ld_we(ld_we1), .ld_addr(ld_addr1), .ld_wdata(ld_wdata1)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever either responder presents rvalid.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rvalid === 1'b1) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid: got rdata %h err %b at cycle %0d, expected none",
                             rdata, err, cyc);
                end else begin
                    e = q0.pop_front();
                    chk("rdata", rdata, e.data);
                    chk("err", 32'(err), 32'(e.err));
                    chk("latency_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (rvalid1 === 1'b1) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid_l1: got rdata %h err %b at cycle %0d, expected none",
                             rdata1, err1, cyc);
                end else begin
                    e = q1.pop_front();
                    chk("l1_rdata", rdata1, e.data);
                    chk("l1_err", 32'(err1), 32'(e.err));
                    chk("l1_latency_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ld(input logic [31:0] a, input logic [31:0] d);
        ld_we = 1'b1; ld_addr = a; ld_wdata = d;
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic e, output int acc);
        int g = 0;
        req = 1'b1; addr = a;
        while (ready !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready %b expected 1 within 20 cycles", ready);
        end
        acc = cyc + 1;
        q0.push_back('{d, e, cyc + LAT});
        @(negedge clk);
        req = 1'b0;
        chk("ready_in_wait", 32'(ready), 32'd0);
    endtask

    localparam logic [31:0] WA = 32'hAAAA_0005;
    localparam logic [31:0] WB = 32'hBBBB_0005;

    logic [31:0] l1_addrs [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h3, 32'h0};
    logic [31:0] l1_data  [6] = '{32'h5000_0000, 32'h5000_0001, 32'h5000_0002,
                                  32'h5000_0003, 32'h0, 32'h5000_0000};
    logic        l1_err   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int a0, a1, a2, tmo;
        rst_n = 1'b0; req = 1'b1; addr = 32'hC;
        ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
        req1 = 1'b0; addr1 = '0; ld_we1 = 1'b0; ld_addr1 = '0; ld_wdata1 = '0;

        // Reset with req held high.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_rvalid", 32'(rvalid), 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        rst_n = 1'b1; req = 1'b0;

        ld(32'hC,   32'h2008_0005);
        ld(32'h0,   32'h1111_0000);
        ld(32'h4,   32'h1111_0001);
        ld(32'h8,   32'h1111_0002);
        ld(32'h14,  WA);
        ld(32'h3FE, 32'hFFEE_00FF);   // low bits ignored -> word 255
        ld(32'h400, 32'hDEAD_BEEF);   // out of range, must not alias to word 0

        fetch(32'hC, 32'h2008_0005, 1'b0, a0);
        idle(3);

        // Back-to-back with req held.
        fetch(32'h0, 32'h1111_0000, 1'b0, a0);
        fetch(32'h4, 32'h1111_0001, 1'b0, a1);
        fetch(32'h8, 32'h1111_0002, 1'b0, a2);
        chk("b2b_spacing_1", 32'(a1 - a0), 32'd2);
        chk("b2b_spacing_2", 32'(a2 - a1), 32'd2);
        idle(3);

        // Errors and range boundaries.
        fetch(32'h6,         32'h0,         1'b1, a0);
        fetch(32'h400,       32'h0,         1'b1, a0);
        fetch(32'hFFFF_FFFC, 32'h0,         1'b1, a0);
        fetch(32'h3FC,       32'hFFEE_00FF, 1'b0, a0);
        fetch(32'h0,         32'h1111_0000, 1'b0, a0);
        idle(3);

        // Loader write to the same word on the edge entering RESP.
        chk("collision_ready", 32'(ready), 32'd1);
        req = 1'b1; addr = 32'h14;
        q0.push_back('{WA, 1'b0, cyc + LAT});
        @(negedge clk);
        req = 1'b0;
        ld_we = 1'b1; ld_addr = 32'h14; ld_wdata = WB;
        @(negedge clk);
        ld_we = 1'b0;
        idle(2);
        fetch(32'h14, WB, 1'b0, a0);
        idle(3);

        // Reset during WAIT drops the fetch.
        req = 1'b1; addr = 32'hC;
        @(negedge clk);
        req = 1'b0;
        chk("midop_in_wait", 32'(ready), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midop_ready", 32'(ready), 32'd1);
        chk("midop_rvalid", 32'(rvalid), 32'd0);
        idle(3);
        fetch(32'hC, 32'h2008_0005, 1'b0, a0);
        idle(3);

        // LATENCY=1 instance: one fetch per edge.
        for (int i = 0; i < 4; i++) begin
            ld_we1 = 1'b1; ld_addr1 = 32'(i * 4); ld_wdata1 = 32'h5000_0000 + 32'(i);
            @(negedge clk);
        end
        ld_we1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req1 = 1'b1; addr1 = l1_addrs[i];
            chk("l1_ready", 32'(ready1), 32'd1);
            q1.push_back('{l1_data[i], l1_err[i], cyc + 1});
            @(negedge clk);
        end
        req1 = 1'b0;

        tmo = 0;
        while ((q0.size() != 0 || q1.size() != 0) && tmo < 20) begin
            @(negedge clk);
            tmo++;
        end
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
